// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter: grants one cycle after request, holds until done/req drop/en low/MAX_HOLD.
// Outputs come straight from flops; a one-cycle idle gap always separates consecutive grants.
module rr_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);
  localparam bit                TO_EN      = (MAX_HOLD != 0);

  state_t            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        gnt_idx_q, gnt_idx_d;
  logic              gnt_vld_q, gnt_vld_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              timeout_q, timeout_d;

  logic [1:0]        pick_idx;
  logic              pick_any;
  logic [1:0]        cand;
  logic              hold_expired;

  // Walk from the farthest offset down so the one closest to ptr wins.
  always_comb begin
    pick_idx = 2'd0;
    pick_any = 1'b0;
    cand     = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_q + 2'(i);
      if (req[cand]) begin
        pick_idx = cand;
        pick_any = 1'b1;
      end
    end
  end

  assign hold_expired = TO_EN && (cnt_q == MAX_HOLD_C);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_idx_d = gnt_idx_q;
    gnt_vld_d = gnt_vld_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_vld_d = 1'b0;
        if (en && pick_any) begin
          gnt_idx_d = pick_idx;
          gnt_vld_d = 1'b1;
          cnt_d     = HOLD_W'(1);
          state_d   = GRANT;
        end
      end
      GRANT: begin
        if (!en || done || !req[gnt_idx_q] || hold_expired) begin
          // Only a pure hold expiry counts as a forced release.
          timeout_d = en && !done && req[gnt_idx_q];
          gnt_vld_d = 1'b0;
          ptr_d     = gnt_idx_q + 2'd1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        gnt_vld_d = 1'b0;
        cnt_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      gnt_idx_q <= 2'd0;
      gnt_vld_q <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_vld_q <= gnt_vld_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    gnt = 4'b0000;
    if (gnt_vld_q) gnt[gnt_idx_q] = 1'b1;
  end

  assign gnt_idx = gnt_idx_q;
  assign gnt_vld = gnt_vld_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4 with MAX_HOLD=4; each task checks its own scenario inline.
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  int checks;
  int errors;

  rr_arbiter_4 #(.MAX_HOLD(4), .HOLD_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    en   = 1'b0;
    req  = 4'b0000;
    done = 1'b0;
    #2;
    rst  = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    en   = 1'b0;
    req  = 4'b0000;
    done = 1'b0;
    #2;
    checks++;
    if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || gnt_idx !== 2'd0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got gnt=%b vld=%b idx=%0d to=%b, want 0000/0/0/0", gnt, gnt_vld, gnt_idx, timeout);
    end
    rst = 1'b0;
    en  = 1'b1;
    req = 4'b1111;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0010 || gnt_idx !== 2'd1) begin
      errors++;
      $display("FAIL reset_pregrant: got gnt=%b idx=%0d, want 0010/1", gnt, gnt_idx);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || timeout !== 1'b0 || gnt_idx !== 2'd0) begin
      errors++;
      $display("FAIL reset_async: got gnt=%b vld=%b idx=%0d to=%b, want 0000/0/0/0", gnt, gnt_vld, gnt_idx, timeout);
    end
    #1;
    rst = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0001 || gnt_idx !== 2'd0 || gnt_vld !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant: got gnt=%b idx=%0d vld=%b, want 0001/0/1", gnt, gnt_idx, gnt_vld);
    end
  endtask

  task automatic test_single();
    do_reset();
    en  = 1'b1;
    req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (gnt !== 4'b0100 || gnt_idx !== 2'd2 || gnt_vld !== 1'b1) begin
        errors++;
        $display("FAIL single_hold cycle %0d: got gnt=%b idx=%0d vld=%b, want 0100/2/1", c, gnt, gnt_idx, gnt_vld);
      end
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || gnt_idx !== 2'd2 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL single_release: got gnt=%b vld=%b idx=%0d to=%b, want 0000/0/2/0", gnt, gnt_vld, gnt_idx, timeout);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (gnt !== 4'b0100 || gnt_idx !== 2'd2) begin
      errors++;
      $display("FAIL single_regrant: got gnt=%b idx=%0d, want 0100/2", gnt, gnt_idx);
    end
  endtask

  task automatic test_rotation();
    logic [1:0] order [6];
    logic [3:0] exp_gnt;
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    en  = 1'b1;
    req = 4'b1111;
    for (int g = 0; g < 6; g++) begin
      exp_gnt = 4'b0001 << order[g];
      tick();
      checks++;
      if (gnt !== exp_gnt || gnt_idx !== order[g] || gnt_vld !== 1'b1) begin
        errors++;
        $display("FAIL rotation_grant %0d: got gnt=%b idx=%0d vld=%b, want %b/%0d/1", g, gnt, gnt_idx, gnt_vld, exp_gnt, order[g]);
      end
      tick();
      checks++;
      if (gnt !== exp_gnt) begin
        errors++;
        $display("FAIL rotation_hold %0d: got gnt=%b, want %b", g, gnt, exp_gnt);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      checks++;
      if (gnt !== 4'b0000 || gnt_vld !== 1'b0) begin
        errors++;
        $display("FAIL rotation_gap %0d: got gnt=%b vld=%b, want 0000/0", g, gnt, gnt_vld);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    en  = 1'b1;
    req = 4'b0011;
    tick();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (gnt !== 4'b0001 || gnt_vld !== 1'b1 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL timeout_hold cycle %0d: got gnt=%b vld=%b to=%b, want 0001/1/0", c, gnt, gnt_vld, timeout);
      end
      tick();
    end
    checks++;
    if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_pulse: got gnt=%b vld=%b to=%b, want 0000/0/1", gnt, gnt_vld, timeout);
    end
    tick();
    checks++;
    if (gnt !== 4'b0010 || gnt_idx !== 2'd1 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_next: got gnt=%b idx=%0d to=%b, want 0010/1/0", gnt, gnt_idx, timeout);
    end
  endtask

  task automatic test_enable_drop();
    do_reset();
    en  = 1'b1;
    req = 4'b0010;
    tick();
    en = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL enable_revoke: got gnt=%b vld=%b to=%b, want 0000/0/0", gnt, gnt_vld, timeout);
    end
    tick();
    tick();
    checks++;
    if (gnt_vld !== 1'b0) begin
      errors++;
      $display("FAIL enable_block: got vld=%b, want 0", gnt_vld);
    end
    en = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0010 || gnt_idx !== 2'd1) begin
      errors++;
      $display("FAIL enable_regrant: got gnt=%b idx=%0d, want 0010/1", gnt, gnt_idx);
    end
    req = 4'b1101;
    tick();
    checks++;
    if (gnt_vld !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reqdrop_release: got vld=%b to=%b, want 0/0", gnt_vld, timeout);
    end
    tick();
    checks++;
    if (gnt !== 4'b0100 || gnt_idx !== 2'd2) begin
      errors++;
      $display("FAIL reqdrop_ptr: got gnt=%b idx=%0d, want 0100/2", gnt, gnt_idx);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    en  = 1'b1;
    req = 4'b0001;
    tick();
    tick();
    tick();
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (gnt_vld !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL simul_done_wins: got vld=%b to=%b, want 0/0", gnt_vld, timeout);
    end
    req = 4'b1001;
    tick();
    checks++;
    if (gnt !== 4'b1000 || gnt_idx !== 2'd3) begin
      errors++;
      $display("FAIL simul_ptr_skip: got gnt=%b idx=%0d, want 1000/3", gnt, gnt_idx);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    en     = 1'b0;
    req    = 4'b0000;
    done   = 1'b0;
    test_reset();
    test_single();
    test_rotation();
    test_timeout();
    test_enable_drop();
    test_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
